data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl_if.sv | 26 ++
 rtl/data_memory_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between a load/store requester and data_memory_ctrl.
// The master issues single-beat requests; the slave returns a one-cycle completion pulse.
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressable single-port data memory with a fixed-latency request/response FSM.
// Optional DATA_MEMORY_MISALIGN_TRAP_EN: reject misaligned and reserved-size accesses with resp_error.
module data_memory_ctrl #(
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [2:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [2:0]        wait_cnt_reg, wait_cnt_next;
  logic              accept;
  logic              fire;

  logic              write_reg;
  logic [1:0]        size_reg;
  logic              unsigned_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              err_reg;

  logic              op_write;
  logic [1:0]        op_size;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [IDX_W-1:0]  op_idx;
  logic [3:0]        op_be;
  logic [31:0]       op_wword;
  logic              op_err;
  logic              mem_we;

  logic [31:0]       rd_word;
  logic [31:0]       rdata_fmt;
  logic [7:0]        rd_byte_sel;
  logic [15:0]       rd_half_sel;

  assign bus.req_ready = (state_reg == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 3'd0;
      write_reg    <= 1'b0;
      size_reg     <= 2'b00;
      unsigned_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= 32'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (accept) begin
        write_reg    <= bus.req_write;
        size_reg     <= bus.req_size;
        unsigned_reg <= bus.req_unsigned;
        addr_reg     <= bus.req_addr;
        wdata_reg    <= bus.req_wdata;
      end
      if (fire) begin
        err_reg <= op_err;
      end
    end
  end

  // fire marks the edge that enters RESP: the only edge on which memory is touched.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    fire          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            fire       = 1'b1;
          end else begin
            state_next    = WAIT;
            wait_cnt_next = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_reg == 3'd0) begin
          state_next = RESP;
          fire       = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg - 3'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = 3'd0;
      end
    endcase
  end

  // With no wait states the access happens on the accept edge, so the live request is used.
  assign op_write = (state_reg == IDLE) ? bus.req_write : write_reg;
  assign op_size  = (state_reg == IDLE) ? bus.req_size  : size_reg;
  assign op_addr  = (state_reg == IDLE) ? bus.req_addr  : addr_reg;
  assign op_wdata = (state_reg == IDLE) ? bus.req_wdata : wdata_reg;
  assign op_idx   = op_addr[IDX_W+1:2];

  always_comb begin
    op_be    = 4'b1111;
    op_wword = op_wdata;
    case (op_size)
      2'b00: begin
        op_be    = 4'b0001 << op_addr[1:0];
        op_wword = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        op_be    = op_addr[1] ? 4'b1100 : 4'b0011;
        op_wword = {2{op_wdata[15:0]}};
      end
      default: begin
        op_be    = 4'b1111;
        op_wword = op_wdata;
      end
    endcase
  end

`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
  assign op_err = ((op_size == 2'b01) && op_addr[0]) ||
                  ((op_size == 2'b10) && (op_addr[1:0] != 2'b00)) ||
                  (op_size == 2'b11);
`else
  assign op_err = 1'b0;
`endif

  assign mem_we = fire && op_write && !op_err && !reset;

  // One byte-wide RAM per lane keeps byte-enable writes free of read-modify-write.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH] = '{default: 8'h00};
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (mem_we && op_be[gi]) begin
          mem_lane[op_idx] <= op_wword[gi*8 +: 8];
        end
        if (fire) begin
          rd_byte_reg <= mem_lane[op_idx];
        end
      end

      assign rd_word[gi*8 +: 8] = rd_byte_reg;
    end
  endgenerate

  always_comb begin
    rd_byte_sel = rd_word[7:0];
    case (addr_reg[1:0])
      2'b00:   rd_byte_sel = rd_word[7:0];
      2'b01:   rd_byte_sel = rd_word[15:8];
      2'b10:   rd_byte_sel = rd_word[23:16];
      default: rd_byte_sel = rd_word[31:24];
    endcase
    rd_half_sel = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];

    rdata_fmt = rd_word;
    case (size_reg)
      2'b00:   rdata_fmt = unsigned_reg ? {24'd0, rd_byte_sel}
                                        : {{24{rd_byte_sel[7]}}, rd_byte_sel};
      2'b01:   rdata_fmt = unsigned_reg ? {16'd0, rd_half_sel}
                                        : {{16{rd_half_sel[15]}}, rd_half_sel};
      default: rdata_fmt = rd_word;
    endcase
  end

  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_rdata = (bus.resp_valid && !write_reg && !err_reg) ? rdata_fmt : 32'd0;
  assign bus.resp_error = bus.resp_valid && err_reg;

  generate
    if (ADDR_W > IDX_W + 2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^op_addr[ADDR_W-1:IDX_W+2];
    end
  endgenerate

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: one instance with no wait states, one with three.
// Stimulus pushes expected responses; per-instance monitors pop and compare on resp_valid.
module tb_data_memory_ctrl;

  localparam int WAIT_A = 0;
  localparam int WAIT_B = 3;
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  logic clk;
  logic reset;

  data_memory_ctrl_if #(.ADDR_W(32)) ia ();
  data_memory_ctrl_if #(.ADDR_W(32)) ib ();

  data_memory_ctrl #(.DEPTH(64), .ADDR_W(32), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  data_memory_ctrl #(.DEPTH(64), .ADDR_W(32), .WAIT_CYCLES(WAIT_B)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic get_ready(input int w);
    return (w == 0) ? ia.req_ready : ib.req_ready;
  endfunction

  function automatic logic get_valid(input int w);
    return (w == 0) ? ia.resp_valid : ib.resp_valid;
  endfunction

  task automatic drive(input int w, input logic v, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    if (w == 0) begin
      ia.req_valid = v; ia.req_write = wr; ia.req_size = sz;
      ia.req_unsigned = uns; ia.req_addr = addr; ia.req_wdata = wd;
    end else begin
      ib.req_valid = v; ib.req_write = wr; ib.req_size = sz;
      ib.req_unsigned = uns; ib.req_addr = addr; ib.req_wdata = wd;
    end
  endtask

  // Called in the low clock phase; returns in the low phase after the response completes.
  task automatic issue(input int w, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
    int   lat;
    int   exp_lat;
    exp_t e;
    exp_lat = ((w == 0) ? WAIT_A : WAIT_B) + 1;
    drive(w, 1'b1, wr, sz, uns, addr, wd);
    lat = 0;
    while (!get_ready(w) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!get_ready(w)) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready 0 required 1 within 20 cycles");
      drive(w, 1'b0, 1'b0, SZ_W, 1'b0, 32'd0, 32'd0);
      return;
    end
    e.rdata = exp_rd;
    e.err   = exp_err;
    if (w == 0) q_a.push_back(e); else q_b.push_back(e);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, 1'b0, SZ_W, 1'b0, 32'd0, 32'd0);
    lat = 1;
    while (!get_valid(w) && lat < 20) begin
      check("ready_busy", {31'd0, get_ready(w)}, 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("ready_in_resp", {31'd0, get_ready(w)}, 32'd0);
    @(negedge clk);
    check("resp_pulse_end", {31'd0, get_valid(w)}, 32'd0);
    check("ready_after_resp", {31'd0, get_ready(w)}, 32'd1);
    $display("txn dut=%0d wr=%0b size=%0d uns=%0b addr=%h wdata=%h exp_rdata=%h exp_err=%0b lat=%0d",
             w, wr, sz, uns, addr, wd, exp_rd, exp_err, lat);
  endtask

  always @(negedge clk) begin
    if (ia.resp_valid) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_resp: got resp_valid 1 required 0");
      end else begin
        e_a = q_a.pop_front();
        check("a_rdata", ia.resp_rdata, e_a.rdata);
        check("a_error", {31'd0, ia.resp_error}, {31'd0, e_a.err});
      end
    end else begin
      check("a_idle_rdata", ia.resp_rdata, 32'd0);
      check("a_idle_error", {31'd0, ia.resp_error}, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (ib.resp_valid) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_resp: got resp_valid 1 required 0");
      end else begin
        e_b = q_b.pop_front();
        check("b_rdata", ib.resp_rdata, e_b.rdata);
        check("b_error", {31'd0, ib.resp_error}, {31'd0, e_b.err});
      end
    end else begin
      check("b_idle_rdata", ib.resp_rdata, 32'd0);
      check("b_idle_error", {31'd0, ib.resp_error}, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish before 500000");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, SZ_W, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, SZ_W, 1'b0, 32'd0, 32'd0);
    #2;
    check("rst_ready_a", {31'd0, ia.req_ready}, 32'd0);
    check("rst_ready_b", {31'd0, ib.req_ready}, 32'd0);
    check("rst_valid_a", {31'd0, ia.resp_valid}, 32'd0);
    check("rst_valid_b", {31'd0, ib.resp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready_a", {31'd0, ia.req_ready}, 32'd1);
    check("post_rst_ready_b", {31'd0, ib.req_ready}, 32'd1);

    // No wait states: word, byte and half accesses with sign/zero extension.
    issue(0, 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    issue(0, 1'b1, SZ_W, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    issue(0, 1'b1, SZ_B, 1'b0, 32'h11, 32'h80, 32'h0, 1'b0);
    issue(0, 1'b0, SZ_B, 1'b0, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0);
    issue(0, 1'b0, SZ_B, 1'b1, 32'h11, 32'h0, 32'h00000080, 1'b0);
    issue(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h00008000, 1'b0);
    issue(0, 1'b0, SZ_H, 1'b0, 32'h10, 32'h0, 32'hFFFF8000, 1'b0);
    issue(0, 1'b1, SZ_B, 1'b0, 32'h13, 32'h123456A5, 32'h0, 1'b0);
    issue(0, 1'b0, SZ_W, 1'b1, 32'h10, 32'h0, 32'hA5008000, 1'b0);

    // Address wrap modulo DEPTH*4.
    issue(0, 1'b1, SZ_W, 1'b0, 32'h100, 32'h12345678, 32'h0, 1'b0);
    issue(0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0);

    // Misaligned half store and reserved/misaligned loads.
    issue(0, 1'b1, SZ_W, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    issue(0, 1'b1, SZ_H, 1'b0, 32'h2, 32'hBEEF, 32'h0, 1'b0);
    issue(0, 1'b1, SZ_H, 1'b0, 32'h3, 32'hBEEF, 32'h0, TRAP);
    issue(0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'hBEEF0000, 1'b0);
    issue(0, 1'b0, SZ_H, 1'b1, 32'h2, 32'h0, 32'h0000BEEF, 1'b0);
    issue(0, 1'b0, SZ_H, 1'b0, 32'h2, 32'h0, 32'hFFFFBEEF, 1'b0);
    issue(0, 1'b0, SZ_B, 1'b0, 32'h3, 32'h0, 32'hFFFFFFBE, 1'b0);
    issue(0, 1'b0, SZ_H, 1'b0, 32'h3, 32'h0, TRAP ? 32'h0 : 32'hFFFFBEEF, TRAP);
    issue(0, 1'b0, SZ_R, 1'b0, 32'h0, 32'h0, TRAP ? 32'h0 : 32'hBEEF0000, TRAP);
    issue(0, 1'b0, SZ_W, 1'b0, 32'h12, 32'h0, TRAP ? 32'h0 : 32'hA5008000, TRAP);

    // Three wait states.
    issue(1, 1'b1, SZ_W, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0);
    issue(1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0);

    // Reset while a store sits in WAIT: nothing committed, no response.
    drive(1, 1'b1, 1'b1, SZ_W, 1'b0, 32'h20, 32'hAAAAAAAA);
    check("b_ready_before_abort", {31'd0, ib.req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, SZ_W, 1'b0, 32'd0, 32'd0);
    check("b_ready_in_wait", {31'd0, ib.req_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("abort_ready", {31'd0, ib.req_ready}, 32'd0);
    check("abort_valid", {31'd0, ib.resp_valid}, 32'd0);
    check("abort_rdata", ib.resp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready_after", {31'd0, ib.req_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_resp", {31'd0, ib.resp_valid}, 32'd0);
    end
    $display("txn dut=1 store aborted by reset addr=00000020 wdata=aaaaaaaa");
    issue(1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0);
    issue(1, 1'b1, SZ_B, 1'b0, 32'h22, 32'h5A, 32'h0, 1'b0);
    issue(1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h115A3344, 1'b0);

    // Memory of the idle instance survives the reset pulse.
    issue(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hA5008000, 1'b0);

    repeat (2) @(negedge clk);
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pending_responses: got %0d/%0d queued required 0/0", q_a.size(), q_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
